// File: rtl/cmp_result_tracker.sv
// Tallies, run-length tracking and change/error flags for a {gt,eq,lt} comparator result.
// Optional build macro: CMP_TRACKER_STICKY_ERR_EN (err holds until rst_n/clr instead of pulsing).
module cmp_result_tracker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [2:0]       in_cmp,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [2:0]       last_res,
    output logic             stable,
    output logic             chg,
    output logic             err
);

    localparam int unsigned     RUN_W   = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_STABLE,
        ST_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  gt_cnt_q, gt_cnt_d;
    logic [CNT_W-1:0]  eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0]  lt_cnt_q, lt_cnt_d;
    logic [2:0]        last_res_q, last_res_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              stable_q, stable_d;
    logic              chg_q, chg_d;
    logic              err_q, err_d;

    logic              legal;
    logic              same;
    logic [RUN_W-1:0]  run_inc;

    assign legal   = (in_cmp == 3'b001) || (in_cmp == 3'b010) || (in_cmp == 3'b100);
    assign same    = (in_cmp == last_res_q);
    assign run_inc = (run_q >= RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gt_cnt_q   <= '0;
            eq_cnt_q   <= '0;
            lt_cnt_q   <= '0;
            last_res_q <= 3'b000;
            run_q      <= '0;
            stable_q   <= 1'b0;
            chg_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gt_cnt_q   <= gt_cnt_d;
            eq_cnt_q   <= eq_cnt_d;
            lt_cnt_q   <= lt_cnt_d;
            last_res_q <= last_res_d;
            run_q      <= run_d;
            stable_q   <= stable_d;
            chg_q      <= chg_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gt_cnt_d   = gt_cnt_q;
        eq_cnt_d   = eq_cnt_q;
        lt_cnt_d   = lt_cnt_q;
        last_res_d = last_res_q;
        run_d      = run_q;
        chg_d      = 1'b0;
`ifdef CMP_TRACKER_STICKY_ERR_EN
        err_d      = err_q;
`else
        err_d      = 1'b0;
`endif

        if (clr) begin
            state_d    = ST_IDLE;
            gt_cnt_d   = '0;
            eq_cnt_d   = '0;
            lt_cnt_d   = '0;
            last_res_d = 3'b000;
            run_d      = '0;
            err_d      = 1'b0;
        end else if (in_valid) begin
            if (legal) begin
                // Saturating tallies: hold once all ones.
                if (in_cmp[2] && !(&gt_cnt_q)) gt_cnt_d = gt_cnt_q + CNT_W'(1);
                if (in_cmp[1] && !(&eq_cnt_q)) eq_cnt_d = eq_cnt_q + CNT_W'(1);
                if (in_cmp[0] && !(&lt_cnt_q)) lt_cnt_d = lt_cnt_q + CNT_W'(1);

                if (same) begin
                    run_d = run_inc;
                end else begin
                    run_d      = RUN_W'(1);
                    last_res_d = in_cmp;
                end

                case (state_q)
                    ST_TRACK: begin
                        if (same) state_d = (run_q + RUN_W'(1) == RUN_MAX) ? ST_STABLE : ST_TRACK;
                        else      state_d = ST_TRACK;
                        chg_d = !same;
                    end
                    ST_STABLE: begin
                        if (same) state_d = ST_STABLE;
                        else      state_d = (RUN_LEN == 1) ? ST_STABLE : ST_TRACK;
                        chg_d = !same;
                    end
                    default: state_d = (RUN_LEN == 1) ? ST_STABLE : ST_TRACK;
                endcase
            end else begin
                state_d    = ST_ERR;
                run_d      = '0;
                last_res_d = 3'b000;
                err_d      = 1'b1;
            end
        end

        stable_d = (state_d == ST_STABLE);
    end

    assign gt_cnt   = gt_cnt_q;
    assign eq_cnt   = eq_cnt_q;
    assign lt_cnt   = lt_cnt_q;
    assign last_res = last_res_q;
    assign stable   = stable_q;
    assign chg      = chg_q;
    assign err      = err_q;

endmodule
